// File: rtl/pio_pkg.sv
// Shared definitions for the PIO command-port loader: action codes and sequencer states.
package pio_pkg;

  localparam logic [3:0] ACT_NONE  = 4'd0;
  localparam logic [3:0] ACT_INSTR = 4'd1;
  localparam logic [3:0] ACT_PEND  = 4'd2;
  localparam logic [3:0] ACT_PULL  = 4'd3;
  localparam logic [3:0] ACT_PUSH  = 4'd4;
  localparam logic [3:0] ACT_GRPS  = 4'd5;
  localparam logic [3:0] ACT_EN    = 4'd6;
  localparam logic [3:0] ACT_DIV   = 4'd7;
  localparam logic [3:0] ACT_SHIFT = 4'd10;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_DIS,
    ST_LOAD,
    ST_PEND,
    ST_DIV,
    ST_GRPS,
    ST_SHIFT,
    ST_ENA,
    ST_RUN
  } loader_state_t;

endpackage

// File: rtl/pio_rr_arb.sv
// Two-requester round-robin arbiter; the grant is combinational, the last winner is registered.
module pio_rr_arb (
  input  logic       i_clk,
  input  logic       i_reset,
  input  logic [1:0] i_req,
  output logic [1:0] o_gnt
);

  // Set when requester 1 won most recently, so requester 0 goes first after reset.
  logic r_last;

  always_comb begin
    o_gnt = i_req;
    if (i_req == 2'b11) begin
      o_gnt = r_last ? 2'b01 : 2'b10;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_last <= 1'b1;
    end else if (o_gnt != 2'b00) begin
      r_last <= o_gnt[1];
    end
  end

endmodule

// File: rtl/pio_loader.sv
// Owns the PIO command port: loads program and config on start, then arbitrates host TX/RX traffic.
module pio_loader
  import pio_pkg::*;
#(
  parameter int ADDR_W = 5
) (
  input  logic              i_clk,
  input  logic              i_reset,
  input  logic              i_start,
  input  logic [1:0]        i_sm,
  input  logic [5:0]        i_plen,
  input  logic [31:0]       i_pend,
  input  logic [23:0]       i_div,
  input  logic [31:0]       i_grps,
  input  logic [31:0]       i_shift,
  output logic              o_busy,
  output logic              o_done,
  output logic              o_err,
  output logic [ADDR_W-1:0] o_prog_addr,
  input  logic [15:0]       i_prog_data,
  input  logic              i_tx_valid,
  input  logic [31:0]       i_tx_data,
  output logic              o_tx_ready,
  output logic              o_rx_valid,
  output logic [31:0]       o_rx_data,
  input  logic              i_rx_ready,
  output logic [3:0]        o_action,
  output logic [4:0]        o_index,
  output logic [1:0]        o_mindex,
  output logic [31:0]       o_din,
  input  logic [31:0]       i_dout,
  input  logic [3:0]        i_full,
  input  logic [3:0]        i_empty
);

  localparam logic [31:0] MAX_LEN = 32'(2**ADDR_W);

  loader_state_t     r_state;
  logic [1:0]        r_sm;
  logic [5:0]        r_plen;
  logic [31:0]       r_pend;
  logic [23:0]       r_div;
  logic [31:0]       r_grps;
  logic [31:0]       r_shift;
  logic [ADDR_W-1:0] r_idx;
  logic [ADDR_W-1:0] r_prog_addr;
  logic              r_busy;
  logic              r_done;
  logic              r_err;
  logic              r_fin;
  logic              r_pull_q;
  logic              r_rx_valid;
  logic [31:0]       r_rx_data;
  logic [3:0]        r_action;
  logic [4:0]        r_index;
  logic [31:0]       r_din;

  logic              w_plen_ok;
  logic              w_start_ok;
  logic              w_accept;
  logic              w_run;
  logic              w_last;
  logic [1:0]        w_req;
  logic [1:0]        w_gnt;

  assign w_plen_ok  = (i_plen != 6'd0) && (32'(i_plen) <= MAX_LEN);
  assign w_start_ok = i_start && !r_busy && (r_state == ST_IDLE || r_state == ST_RUN);
  assign w_accept   = w_start_ok && w_plen_ok;
  // The cycle that accepts a reload issues no transfer.
  assign w_run      = (r_state == ST_RUN) && !w_accept;
  assign w_last     = (32'(r_idx) + 32'd1 == 32'(r_plen));

  assign w_req[0] = w_run && i_tx_valid && !i_full[r_sm];
  assign w_req[1] = w_run && !i_empty[r_sm] && !r_rx_valid && !r_pull_q;

  pio_rr_arb u_arb (
    .i_clk   (i_clk),
    .i_reset (i_reset),
    .i_req   (w_req),
    .o_gnt   (w_gnt)
  );

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_state     <= ST_IDLE;
      r_sm        <= 2'd0;
      r_plen      <= 6'd0;
      r_pend      <= 32'd0;
      r_div       <= 24'd0;
      r_grps      <= 32'd0;
      r_shift     <= 32'd0;
      r_idx       <= '0;
      r_prog_addr <= '0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_err       <= 1'b0;
      r_fin       <= 1'b0;
      r_pull_q    <= 1'b0;
      r_rx_valid  <= 1'b0;
      r_rx_data   <= 32'd0;
      r_action    <= ACT_NONE;
      r_index     <= 5'd0;
      r_din       <= 32'd0;
    end else begin
      r_action <= ACT_NONE;
      r_done   <= 1'b0;
      r_err    <= w_start_ok && !w_plen_ok;
      r_pull_q <= 1'b0;

      // PULL data arrives the cycle after the action, regardless of sequencer state.
      if (r_pull_q) begin
        r_rx_data  <= i_dout;
        r_rx_valid <= 1'b1;
      end else if (r_rx_valid && i_rx_ready) begin
        r_rx_valid <= 1'b0;
      end

      case (r_state)
        ST_IDLE, ST_RUN: begin
          if (w_accept) begin
            r_sm        <= i_sm;
            r_plen      <= i_plen;
            r_pend      <= i_pend;
            r_div       <= i_div;
            r_grps      <= i_grps;
            r_shift     <= i_shift;
            r_idx       <= '0;
            r_prog_addr <= '0;
            r_busy      <= 1'b1;
            r_fin       <= 1'b0;
            r_state     <= ST_DIS;
          end else if (r_state == ST_RUN) begin
            if (r_fin) begin
              r_fin  <= 1'b0;
              r_done <= 1'b1;
              r_busy <= 1'b0;
            end
            if (w_gnt[0]) begin
              r_action <= ACT_PUSH;
              r_din    <= i_tx_data;
            end else if (w_gnt[1]) begin
              r_action <= ACT_PULL;
              r_pull_q <= 1'b1;
            end
          end
        end
        ST_DIS: begin
          r_action    <= ACT_EN;
          r_din       <= 32'd0;
          r_prog_addr <= ADDR_W'(1);
          r_state     <= ST_LOAD;
        end
        ST_LOAD: begin
          r_action    <= ACT_INSTR;
          r_index     <= 5'(r_idx);
          r_din       <= {16'h0, i_prog_data};
          r_prog_addr <= r_idx + ADDR_W'(2);
          r_idx       <= r_idx + ADDR_W'(1);
          if (w_last) begin
            r_state <= ST_PEND;
          end
        end
        ST_PEND: begin
          r_action <= ACT_PEND;
          r_din    <= r_pend;
          r_state  <= ST_DIV;
        end
        ST_DIV: begin
          r_action <= ACT_DIV;
          r_din    <= {8'h0, r_div};
          r_state  <= ST_GRPS;
        end
        ST_GRPS: begin
          r_action <= ACT_GRPS;
          r_din    <= r_grps;
          r_state  <= ST_SHIFT;
        end
        ST_SHIFT: begin
          r_action <= ACT_SHIFT;
          r_din    <= r_shift;
          r_state  <= ST_ENA;
        end
        ST_ENA: begin
          r_action <= ACT_EN;
          r_din    <= 32'd1;
          r_fin    <= 1'b1;
          r_state  <= ST_RUN;
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign o_busy      = r_busy;
  assign o_done      = r_done;
  assign o_err       = r_err;
  assign o_prog_addr = r_prog_addr;
  assign o_tx_ready  = w_gnt[0];
  assign o_rx_valid  = r_rx_valid;
  assign o_rx_data   = r_rx_data;
  assign o_action    = r_action;
  assign o_index     = r_index;
  assign o_mindex    = r_sm;
  assign o_din       = r_din;

endmodule

// File: tb/tb_pio_loader.sv
// Directed bench for pio_loader: table-driven load sequence plus hand-written RUN-mode sequences.
module tb_pio_loader;
  import pio_pkg::*;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [1:0]  sm;
  logic [5:0]  plen;
  logic [31:0] pend;
  logic [23:0] div;
  logic [31:0] grps;
  logic [31:0] shift;
  logic        busy;
  logic        done;
  logic        err;
  logic [4:0]  prog_addr;
  logic [15:0] rom_q;
  logic        tx_valid;
  logic [31:0] tx_data;
  logic        tx_ready;
  logic        rx_valid;
  logic [31:0] rx_data;
  logic        rx_ready;
  logic [3:0]  action;
  logic [4:0]  index;
  logic [1:0]  mindex;
  logic [31:0] din;
  logic [31:0] dout;
  logic [3:0]  full;
  logic [3:0]  empty;

  logic [15:0] rom [32];

  int n_checks = 0;
  int n_err    = 0;

  always #5 clk = ~clk;

  always @(posedge clk) rom_q <= rom[prog_addr];

  pio_loader #(.ADDR_W(5)) dut (
    .i_clk       (clk),
    .i_reset     (reset),
    .i_start     (start),
    .i_sm        (sm),
    .i_plen      (plen),
    .i_pend      (pend),
    .i_div       (div),
    .i_grps      (grps),
    .i_shift     (shift),
    .o_busy      (busy),
    .o_done      (done),
    .o_err       (err),
    .o_prog_addr (prog_addr),
    .i_prog_data (rom_q),
    .i_tx_valid  (tx_valid),
    .i_tx_data   (tx_data),
    .o_tx_ready  (tx_ready),
    .o_rx_valid  (rx_valid),
    .o_rx_data   (rx_data),
    .i_rx_ready  (rx_ready),
    .o_action    (action),
    .o_index     (index),
    .o_mindex    (mindex),
    .o_din       (din),
    .i_dout      (dout),
    .i_full      (full),
    .i_empty     (empty)
  );

  typedef struct {
    logic        start;
    logic [5:0]  plen;
    logic [3:0]  act;
    logic [4:0]  idx;
    logic [31:0] din;
    logic        busy;
    logic        done;
    logic        err;
  } vec_t;

  vec_t tbl [11];

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", nm, got, exp);
    end
  endtask

  task automatic edge_step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_cfg();
    sm    = 2'd0;
    pend  = 32'h0000_1000;
    div   = 24'h00_0100;
    grps  = 32'h0010_0000;
    shift = 32'hA008_0000;
  endtask

  // Row i drives start/plen ahead of edge i and checks the outputs registered at edge i.
  task automatic run_load_table();
    for (int i = 0; i < 11; i++) begin
      start = tbl[i].start;
      plen  = tbl[i].plen;
      edge_step();
      start = 1'b0;
      if (i == 0) begin
        sm = 2'd3; pend = 32'hFFFF_FFFF; div = 24'hFFFFFF; grps = 32'd0; shift = 32'd0;
      end
      chk($sformatf("load%0d action", i), 32'(action), 32'(tbl[i].act));
      chk($sformatf("load%0d busy", i), 32'(busy), 32'(tbl[i].busy));
      chk($sformatf("load%0d done", i), 32'(done), 32'(tbl[i].done));
      chk($sformatf("load%0d err", i), 32'(err), 32'(tbl[i].err));
      if (tbl[i].act != ACT_NONE) chk($sformatf("load%0d din", i), din, tbl[i].din);
      if (tbl[i].act == ACT_INSTR) chk($sformatf("load%0d index", i), 32'(index), 32'(tbl[i].idx));
    end
    chk("load mindex", 32'(mindex), 32'd0);
    set_cfg();
  endtask

  logic [3:0] alt_exp [8];
  int         w;
  logic       f;

  initial begin
    for (int i = 0; i < 32; i++) rom[i] = 16'h1000 + 16'(i);
    rom[0] = 16'h6001;
    rom[1] = 16'h0000;

    tbl[0]  = '{1'b1, 6'd2, ACT_NONE,  5'd0, 32'd0,          1'b1, 1'b0, 1'b0};
    tbl[1]  = '{1'b0, 6'd2, ACT_EN,    5'd0, 32'd0,          1'b1, 1'b0, 1'b0};
    tbl[2]  = '{1'b0, 6'd2, ACT_INSTR, 5'd0, 32'h0000_6001,  1'b1, 1'b0, 1'b0};
    tbl[3]  = '{1'b1, 6'd5, ACT_INSTR, 5'd1, 32'h0000_0000,  1'b1, 1'b0, 1'b0};
    tbl[4]  = '{1'b0, 6'd2, ACT_PEND,  5'd0, 32'h0000_1000,  1'b1, 1'b0, 1'b0};
    tbl[5]  = '{1'b0, 6'd2, ACT_DIV,   5'd0, 32'h0000_0100,  1'b1, 1'b0, 1'b0};
    tbl[6]  = '{1'b0, 6'd2, ACT_GRPS,  5'd0, 32'h0010_0000,  1'b1, 1'b0, 1'b0};
    tbl[7]  = '{1'b0, 6'd2, ACT_SHIFT, 5'd0, 32'hA008_0000,  1'b1, 1'b0, 1'b0};
    tbl[8]  = '{1'b0, 6'd2, ACT_EN,    5'd0, 32'd1,          1'b1, 1'b0, 1'b0};
    tbl[9]  = '{1'b0, 6'd2, ACT_NONE,  5'd0, 32'd0,          1'b0, 1'b1, 1'b0};
    tbl[10] = '{1'b0, 6'd2, ACT_NONE,  5'd0, 32'd0,          1'b0, 1'b0, 1'b0};

    alt_exp = '{ACT_PUSH, ACT_PULL, ACT_PUSH, ACT_PUSH, ACT_PULL, ACT_PUSH, ACT_PUSH, ACT_PULL};

    reset = 1'b1; start = 1'b0; plen = 6'd2; set_cfg();
    tx_valid = 1'b0; tx_data = 32'd0; rx_ready = 1'b0; dout = 32'd0;
    full = 4'h0; empty = 4'hF;
    edge_step();
    edge_step();
    reset = 1'b0;

    chk("rst action", 32'(action), 32'(ACT_NONE));
    chk("rst index", 32'(index), 32'd0);
    chk("rst mindex", 32'(mindex), 32'd0);
    chk("rst din", din, 32'd0);
    chk("rst busy", 32'(busy), 32'd0);
    chk("rst done", 32'(done), 32'd0);
    chk("rst err", 32'(err), 32'd0);
    chk("rst tx_ready", 32'(tx_ready), 32'd0);
    chk("rst rx_valid", 32'(rx_valid), 32'd0);
    chk("rst rx_data", rx_data, 32'd0);
    chk("rst prog_addr", 32'(prog_addr), 32'd0);

    // Nothing moves before the first load.
    tx_valid = 1'b1; tx_data = 32'h55; empty = 4'hE;
    for (int i = 0; i < 3; i++) begin
      #1 chk("idle tx_ready", 32'(tx_ready), 32'd0);
      edge_step();
      chk("idle action", 32'(action), 32'(ACT_NONE));
    end
    tx_valid = 1'b0; empty = 4'hF;

    run_load_table();
    edge_step();

    // Invalid lengths are rejected from RUN without side effects.
    for (int k = 0; k < 2; k++) begin
      start = 1'b1;
      plen  = (k == 0) ? 6'd0 : 6'd33;
      edge_step();
      start = 1'b0; plen = 6'd2;
      chk($sformatf("err%0d pulse", k), 32'(err), 32'd1);
      chk($sformatf("err%0d busy", k), 32'(busy), 32'd0);
      chk($sformatf("err%0d action", k), 32'(action), 32'(ACT_NONE));
      edge_step();
      chk($sformatf("err%0d clear", k), 32'(err), 32'd0);
      chk($sformatf("err%0d action2", k), 32'(action), 32'(ACT_NONE));
    end

    // Sustained TX with a back-pressure window while full[0] is high.
    w = 0;
    tx_valid = 1'b1;
    for (int c = 0; c < 13; c++) begin
      f = (c >= 4 && c < 7);
      full = {3'b000, f};
      tx_data = 32'(w);
      #1 chk($sformatf("tx%0d ready", c), 32'(tx_ready), 32'(!f));
      edge_step();
      chk($sformatf("tx%0d action", c), 32'(action), f ? 32'(ACT_NONE) : 32'(ACT_PUSH));
      if (!f) begin
        chk($sformatf("tx%0d din", c), din, 32'(w));
        w++;
      end
    end
    chk("tx words", 32'(w), 32'd10);
    tx_valid = 1'b0; full = 4'h0;

    // Single PULL into the RX buffer; host holds it off.
    empty = 4'hE; dout = 32'hDEAD_BEEF; rx_ready = 1'b0;
    edge_step();
    chk("rx pull", 32'(action), 32'(ACT_PULL));
    edge_step();
    chk("rx valid", 32'(rx_valid), 32'd1);
    chk("rx data", rx_data, 32'hDEAD_BEEF);
    chk("rx after", 32'(action), 32'(ACT_NONE));
    for (int c = 0; c < 4; c++) begin
      edge_step();
      chk($sformatf("rx hold%0d action", c), 32'(action), 32'(ACT_NONE));
      chk($sformatf("rx hold%0d valid", c), 32'(rx_valid), 32'd1);
    end
    rx_ready = 1'b1;
    edge_step();
    rx_ready = 1'b0; dout = 32'h1234_5678;
    chk("rx drained", 32'(rx_valid), 32'd0);
    chk("rx drain action", 32'(action), 32'(ACT_NONE));
    edge_step();
    chk("rx pull2", 32'(action), 32'(ACT_PULL));
    edge_step();
    chk("rx data2", rx_data, 32'h1234_5678);
    empty = 4'hF; rx_ready = 1'b1;
    edge_step();
    edge_step();
    rx_ready = 1'b0;

    // Reset at edge 4 of a plen=8 load.
    start = 1'b1; plen = 6'd8;
    edge_step();
    start = 1'b0;
    edge_step();
    chk("rl e1", 32'(action), 32'(ACT_EN));
    edge_step();
    chk("rl e2", 32'(action), 32'(ACT_INSTR));
    edge_step();
    chk("rl e3 idx", 32'(index), 32'd1);
    reset = 1'b1;
    edge_step();
    reset = 1'b0;
    chk("rl action", 32'(action), 32'(ACT_NONE));
    chk("rl busy", 32'(busy), 32'd0);
    tx_valid = 1'b1; empty = 4'hE;
    for (int c = 0; c < 12; c++) begin
      #1 chk($sformatf("rl%0d tx_ready", c), 32'(tx_ready), 32'd0);
      edge_step();
      chk($sformatf("rl%0d action", c), 32'(action), 32'(ACT_NONE));
      chk($sformatf("rl%0d done", c), 32'(done), 32'd0);
    end
    tx_valid = 1'b0; empty = 4'hF; plen = 6'd2;

    run_load_table();

    // Both requesters eligible: round-robin, TX first since reset.
    tx_valid = 1'b1; full = 4'h0; empty = 4'hE; rx_ready = 1'b1; dout = 32'hCAFE_0000;
    for (int c = 0; c < 8; c++) begin
      tx_data = 32'h100 + 32'(c);
      edge_step();
      chk($sformatf("alt%0d action", c), 32'(action), 32'(alt_exp[c]));
      if (alt_exp[c] == ACT_PUSH) chk($sformatf("alt%0d din", c), din, 32'h100 + 32'(c));
    end
    tx_valid = 1'b0; empty = 4'hF;
    edge_step();
    chk("alt rx_data", rx_data, 32'hCAFE_0000);
    edge_step();

    $display("CHECKS %0d ERRORS %0d", n_checks, n_err);
    $finish;
  end

endmodule
